// File: rtl/lif_pkg.sv
// lif_pkg: default parameter constants for the LIF neuron bank, plus a helper
// that sizes the per-neuron refractory counter.
package lif_pkg;

  localparam int WIDTH_DEF            = 8;
  localparam int LEAK_SHIFT_DEF       = 1;
  localparam int REFRACT_DEF          = 2;
  localparam logic [7:0] CHAIN_WEIGHT_DEF = 8'd255;

  // Bits needed to hold REFRACT down to 0. The counter is never narrower than
  // one bit, so REFRACT = 0 still gets a legal (always-zero) register.
  function automatic int rcnt_width(input int refract);
    int w;
    w = $clog2(refract + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lif_cell.sv
// lif_cell: one leaky integrate-and-fire neuron.
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset (state, rcnt, spike -> 0)
//   ena       - update enable; when low, state and rcnt hold and spike drops
//   in_cur    - input current integrated on each non-refractory enabled edge
//   threshold - firing threshold; 0 disables firing
//   spike     - registered one-cycle spike pulse
//   state     - membrane potential
module lif_cell
  import lif_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
  parameter int REFRACT    = REFRACT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] in_cur,
  input  logic [WIDTH-1:0] threshold,
  output logic             spike,
  output logic [WIDTH-1:0] state
);

  localparam int RW = rcnt_width(REFRACT);

  logic [RW-1:0]    rcnt;
  logic [WIDTH:0]   sum_wide;
  logic [WIDTH-1:0] sum_sat;
  logic             fire;

  // state - (state >> LEAK_SHIFT) never underflows, so one extra bit is
  // enough to catch the carry from adding the input current.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    sum_wide = {1'b0, state} - {1'b0, state >> LEAK_SHIFT} + {1'b0, in_cur};
    sum_sat  = sum_wide[WIDTH] ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];
    fire     = (threshold != '0) && (sum_sat >= threshold);
  end

  // Refractory-ness is implicit in rcnt: nonzero means input is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so every cell samples pre-edge values.
    if (!rst_n) begin
      state <= '0;
      rcnt  <= '0;
      spike <= 1'b0;
    end else if (!ena) begin
      spike <= 1'b0;
    end else if (rcnt != '0) begin
      rcnt  <= rcnt - RW'(1);
      state <= '0;
      spike <= 1'b0;
    end else if (fire) begin
      spike <= 1'b1;
      state <= '0;
      rcnt  <= RW'(REFRACT);
    end else begin
      spike <= 1'b0;
      state <= sum_sat;
    end
  end

endmodule

// File: rtl/lif_array.sv
// lif_array: bank of N_NEURONS LIF cells with a shared threshold, optional
// feed-forward chain mode and a state display mux.
//   clk, rst_n - clock and asynchronous active-low reset
//   ena        - update enable for all neurons
//   current    - per-neuron input current, neuron k at [k*WIDTH +: WIDTH]
//   threshold  - shared firing threshold (0 disables firing)
//   chain_en   - neurons k>0 take CHAIN_WEIGHT on a spike of neuron k-1
//   sel        - neuron whose state appears on state_out
//   spike      - per-neuron registered spike pulses
//   state_out  - state of neuron sel, or 0 when sel is out of range
module lif_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS              = 4,
  parameter int WIDTH                  = WIDTH_DEF,
  parameter int LEAK_SHIFT             = LEAK_SHIFT_DEF,
  parameter int REFRACT                = REFRACT_DEF,
  parameter logic [WIDTH-1:0] CHAIN_WEIGHT = WIDTH'(CHAIN_WEIGHT_DEF)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [N_NEURONS*WIDTH-1:0]   current,
  input  logic [WIDTH-1:0]             threshold,
  input  logic                         chain_en,
  input  logic [$clog2(N_NEURONS)-1:0] sel,
  output logic [N_NEURONS-1:0]         spike,
  output logic [WIDTH-1:0]             state_out
);

  logic [WIDTH-1:0] cell_state [N_NEURONS];
  logic [WIDTH-1:0] cell_in    [N_NEURONS];

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_cell
    // Chain input uses the registered spike of the previous neuron, so a
    // wave advances one neuron per edge.
    if (k == 0) begin : g_head
      assign cell_in[k] = current[k*WIDTH +: WIDTH];
    end else begin : g_tail
      assign cell_in[k] = chain_en ? (spike[k-1] ? CHAIN_WEIGHT : '0)
                                   : current[k*WIDTH +: WIDTH];
    end

    lif_cell #(
      .WIDTH      (WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRACT    (REFRACT)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .in_cur    (cell_in[k]),
      .threshold (threshold),
      .spike     (spike[k]),
      .state     (cell_state[k])
    );
  end

  // Out-of-range sel (possible when N_NEURONS is not a power of two) shows 0.
  always_comb begin
    state_out = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (int'(sel) == k) state_out = cell_state[k];
    end
  end

endmodule

// File: tb/tb_lif_array.sv
// tb_lif_array: directed self-checking bench for lif_array with default
// parameters (N_NEURONS=4, WIDTH=8, LEAK_SHIFT=1, REFRACT=2, CHAIN_WEIGHT=255).
module tb_lif_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [31:0] current;
  logic [7:0]  threshold;
  logic        chain_en;
  logic [1:0]  sel;
  logic [3:0]  spike;
  logic [7:0]  state_out;

  int vectors     = 0;
  int miscompares = 0;

  lif_array dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .current   (current),
    .threshold (threshold),
    .chain_en  (chain_en),
    .sel       (sel),
    .spike     (spike),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted and released between edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; current = '0; threshold = '0; chain_en = 1'b0; sel = 2'd0;
    #12;
    // Reset state: every neuron 0, no spikes.
    check("reset_spike", {28'd0, spike}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      sel = k[1:0];
      #1;
      check($sformatf("reset_state_%0d", k), {24'd0, state_out}, 32'd0);
    end
    rst_n = 1'b1;
    sel   = 2'd0;

    // Integration to threshold 200 with constant 100.
    begin
      logic [7:0] seq [7];
      seq = '{8'd100, 8'd150, 8'd175, 8'd188, 8'd194, 8'd197, 8'd199};
      current = {8'd0, 8'd0, 8'd0, 8'd100}; threshold = 8'd200; ena = 1'b1;
      for (int e = 0; e < 7; e++) begin
        step();
        check($sformatf("integ_state_e%0d", e + 1), {24'd0, state_out}, {24'd0, seq[e]});
        check($sformatf("integ_spike_e%0d", e + 1), {28'd0, spike}, 32'd0);
      end
      step();
      check("integ_spike_e8", {28'd0, spike}, 32'd1);
      check("integ_state_e8", {24'd0, state_out}, 32'd0);
      step();
      check("integ_spike_width", {28'd0, spike}, 32'd0);
    end

    // Freeze at 175: three disabled edges, then resume with 188.
    ena = 1'b0; do_reset(); ena = 1'b1;
    step(); step(); step();
    check("freeze_pre", {24'd0, state_out}, 32'd175);
    ena = 1'b0;
    for (int e = 0; e < 3; e++) begin
      step();
      check($sformatf("freeze_state_%0d", e), {24'd0, state_out}, 32'd175);
      check($sformatf("freeze_spike_%0d", e), {28'd0, spike}, 32'd0);
    end
    ena = 1'b1;
    step();
    check("freeze_resume", {24'd0, state_out}, 32'd188);

    // Refractory period: threshold 100, current 100 fires every third edge.
    ena = 1'b0; do_reset();
    threshold = 8'd100; ena = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      check($sformatf("refr_spike_e%0d", e), {28'd0, spike}, (e % 3 == 1) ? 32'd1 : 32'd0);
      check($sformatf("refr_state_e%0d", e), {24'd0, state_out}, 32'd0);
    end

    // Saturation with firing disabled; neuron 1 integrates 10 independently.
    ena = 1'b0; do_reset();
    threshold = 8'd0; current = {8'd0, 8'd0, 8'd10, 8'd255}; ena = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("sat_state_e%0d", e), {24'd0, state_out}, 32'd255);
      check($sformatf("sat_spike_e%0d", e), {28'd0, spike}, 32'd0);
    end
    sel = 2'd1;
    #1;
    check("sel1_state", {24'd0, state_out}, 32'd19);
    sel = 2'd0;

    // Chain mode: direct currents on neurons 1..3 must be ignored.
    ena = 1'b0; do_reset();
    chain_en = 1'b1; threshold = 8'd200; current = {8'd255, 8'd255, 8'd255, 8'd255}; ena = 1'b1;
    begin
      logic [3:0] exp_sp [5];
      exp_sp = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0010};
      for (int e = 0; e < 5; e++) begin
        step();
        check($sformatf("chain_spike_e%0d", e + 1), {28'd0, spike}, {28'd0, exp_sp[e]});
      end
    end
    chain_en = 1'b0;

    // Async reset in the middle of a refractory period.
    ena = 1'b0; do_reset();
    threshold = 8'd100; current = {8'd0, 8'd0, 8'd50, 8'd100}; ena = 1'b1;
    step();
    check("areset_pre_spike", {28'd0, spike}, 32'd1);
    sel = 2'd1;
    #1;
    check("areset_pre_state1", {24'd0, state_out}, 32'd50);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_spike", {28'd0, spike}, 32'd0);
    check("areset_state1", {24'd0, state_out}, 32'd0);
    rst_n = 1'b1;
    sel = 2'd0;
    threshold = 8'd200;
    step();
    // A leftover refractory count would hold neuron 0 at 0 here.
    check("areset_integrate0", {24'd0, state_out}, 32'd100);
    check("areset_post_spike", {28'd0, spike}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lif_array.md
# lif_array

Parametrised bank of N_NEURONS leaky integrate-and-fire neurons sharing one clock, with a runtime threshold, a configurable leak shift, a refractory period and an optional feed-forward chain mode. Each neuron k drives its own spike line. Any one neuron's membrane state can be selected for the 8-bit display path. It replaces the single-neuron `lif` core in the top-level wrapper. `spike` maps to bidirectional outputs, and `state_out` maps to `uo_out`.

## Interface
- N_NEURONS, 4: number of neurons; must be at least 2.
- WIDTH, 8: membrane state, input current and threshold width.
- LEAK_SHIFT, 1: leak per update is `state >> LEAK_SHIFT`; range 1..WIDTH-1.
- REFRACT, 2: cycles a neuron ignores input after a spike; 0 is allowed.
- CHAIN_WEIGHT, 8'd255: current injected into neuron k>0 by a spike of neuron k-1 in chain mode.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- ena, input, 1: update enable; when low, state is frozen.
- current, input, N_NEURONS*WIDTH: per-neuron input current; neuron k uses bits [k*WIDTH +: WIDTH].
- threshold, input, WIDTH: firing threshold shared by all neurons; 0 disables firing.
- chain_en, input, 1: 1 = neurons k>0 take chain input instead of `current`.
- sel, input, $clog2(N_NEURONS): selects the neuron shown on `state_out`.
- spike, output, N_NEURONS: registered one-cycle spike pulse per neuron.
- state_out, output, WIDTH: combinational mux of `state[sel]`; when `sel` is at least N_NEURONS, the value is 0.

## Operation
- Per neuron, registers: `state` (WIDTH bits), `rcnt` ($clog2(REFRACT+1) bits, at least 1), `spike`.
- Reset (rst_n low, asynchronous): all `state`, `rcnt` and `spike` go to 0. This takes effect immediately, even in the middle of an integration or refractory period.
- Input selection for neuron k:
  - `in_k = current[k]` when `chain_en` is 0, or when k = 0.
  - `in_k = spike[k-1] ? CHAIN_WEIGHT : 0` otherwise. This uses the registered spike, so chain propagation costs one cycle per stage.
- Enabled edge (ena = 1), neuron not refractory (`rcnt` == 0):
  - `sum = state - (state >> LEAK_SHIFT) + in_k`, computed in WIDTH+1 bits, then saturated to 2^WIDTH-1.
  - If `threshold` != 0 and `sum` >= `threshold`: `spike` <= 1, `state` <= 0, `rcnt` <= REFRACT.
  - Otherwise: `spike` <= 0, `state` <= saturated `sum`.
- Enabled edge, neuron refractory (`rcnt` != 0): `rcnt` <= `rcnt`-1, `state` stays 0, `spike` <= 0, and `in_k` is discarded.
- Disabled edge (ena = 0): `state` and `rcnt` hold; `spike` <= 0, so a spike is never stretched.
- `threshold` and `chain_en` are sampled every edge. A change applies to the next update, with no pipeline flush.
- Per-neuron state machine, implicit in `rcnt`: INTEGRATE (`rcnt` = 0) -> REFRACTORY on fire (only when REFRACT > 0) -> INTEGRATE after REFRACT enabled edges.

## Timing
- Input-to-spike latency: the spike is visible the cycle after the edge on which the threshold crossing is computed. There is no additional pipeline.
- Chain: neuron k spikes no earlier than k edges after neuron 0.
- Minimum spike period under constant suprathreshold input: REFRACT+1 enabled edges.
- `state_out` is combinational from registered state and `sel`; there is no added latency.

## Structure
- Package `lif_pkg` holds the default parameter constants (WIDTH, LEAK_SHIFT, REFRACT, CHAIN_WEIGHT) and a helper function for the `rcnt` width.
- Sub-module `lif_cell`, one per neuron: parameters WIDTH, LEAK_SHIFT, REFRACT; ports clk, rst_n, ena, in_cur, threshold, spike, state.
- `lif_array` contains only the `lif_cell` instances, the chain input muxing and the `sel` mux.

## Test plan
All scenarios use WIDTH=8 and LEAK_SHIFT=1 unless stated.

- **Integration to threshold:** threshold=200, REFRACT=2, current[0]=100 constant, ena=1.
  - Required: state sequence 100, 150, 175, 188, 194, 197, 199.
  - Required: `spike[0]` is 1 after the 8th edge, with state 0.
- **Refractory period:** threshold=100, current[0]=100, REFRACT=2.
  - Required: `spike[0]` pulses on edges 1, 4, 7, …, each one cycle wide.
  - Required: state stays 0 during the two refractory edges.
- **Saturation and disable:** threshold=0, current[0]=255.
  - Required: state goes 255, then 255 on every edge (sum 383 saturates).
  - Required: `spike` never asserts.
- **Chain mode:** chain_en=1, threshold=200, current[0]=255, CHAIN_WEIGHT=255, N_NEURONS=4.
  - Required: spikes fire in order on neurons 0, 1, 2, 3, each one edge after the previous neuron.
- **Freeze:** at state 175, drop `ena` for 3 cycles.
  - Required: state holds at 175 and `spike` stays 0.
  - Required: the sequence resumes with 188 after `ena` returns high.
- **Async reset mid-operation:** assert rst_n low between clock edges during a refractory period.
  - Required: `spike`, `state_out` and all `rcnt` are 0 immediately.
  - Required: the first enabled edge after release integrates from 0.
